// File: rtl/shift_right_seq.sv
// -----------------------------------------------------------------------------
// shift_right_seq
//   Multi-cycle right shifter for the RV32 execute stage (SRL/SRLI, SRA/SRAI).
//   Shifts one bit position per clock. The final result is registered on
//   `out` and held until the next operation completes.
//
//   Handshake: a request is accepted on a rising edge where ready=1 and
//   start=1. A, B and arith are latched on that edge and may change freely
//   afterwards. start is ignored (not queued) while ready=0. done pulses for
//   exactly one cycle, in the cycle B+1 clocks after the accept edge. done and
//   ready are never high together.
//
//   Optional build macro: SHR_FAST_EN
//     When defined, a SHIFT cycle with cnt>=4 shifts by 4 and subtracts 4
//     from cnt. Results are identical; only the latency shrinks to
//     floor(B/4) + (B mod 4) + 1 cycles.
//
//   Parameters:
//     WIDTH   data width (default 32)
//     SHAMT_W shift-amount width (default 5); 2**SHAMT_W must equal WIDTH
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     start  request, accepted only while ready=1
//     arith  1 = sign fill, 0 = zero fill (latched at accept)
//     A      operand (latched at accept)
//     B      shift amount (latched at accept)
//     ready  high in IDLE
//     busy   high in SHIFT or DONE
//     done   one-cycle pulse; out holds the new result
//     out    registered result
// -----------------------------------------------------------------------------
module shift_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               arith,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] B,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;
  logic               sign;

  // Value of acc/cnt after the current SHIFT cycle. Computed once so the
  // final SHIFT cycle can load `out` directly, making out valid while done=1.
  logic [WIDTH-1:0]   nxt_acc;
  logic [SHAMT_W-1:0] nxt_cnt;

  always_comb begin
    nxt_acc = {sign, acc[WIDTH-1:1]};
    nxt_cnt = cnt - SHAMT_W'(1);
`ifdef SHR_FAST_EN
    if (cnt >= SHAMT_W'(4)) begin
      nxt_acc = {{4{sign}}, acc[WIDTH-1:4]};
      nxt_cnt = cnt - SHAMT_W'(4);
    end
`endif
  end

  // Single FSM block; ready/busy/done are registered alongside the state so
  // they change only on clock edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      sign  <= 1'b0;
      out   <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= A;
            cnt   <= B;
            sign  <= arith & A[WIDTH-1];
            ready <= 1'b0;
            busy  <= 1'b1;
            if (B == '0) begin
              // Zero shift: result is the operand itself, go straight to DONE.
              state <= S_DONE;
              out   <= A;
              done  <= 1'b1;
            end else begin
              state <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          acc <= nxt_acc;
          cnt <= nxt_cnt;
          if (nxt_cnt == '0) begin
            state <= S_DONE;
            out   <= nxt_acc;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          // acc already equals out here; reloading keeps the two consistent.
          out   <= acc;
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_right_seq
//   Directed and randomized bench for shift_right_seq. Expected results come
//   from plain SystemVerilog shift operators (>> and >>>) and expected
//   latencies from the cycle-count formula, independent of the RTL structure.
// -----------------------------------------------------------------------------
module tb_shift_right_seq;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               arith;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] b;
  logic               ready;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   res;

  int checks = 0;
  int errors = 0;

  shift_right_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .arith (arith),
    .A     (a),
    .B     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .out   (res)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] exp_shr(input logic [WIDTH-1:0] av,
                                               input logic [SHAMT_W-1:0] bv,
                                               input logic ar);
    logic signed [WIDTH-1:0] s;
    s = av;
    if (ar) return WIDTH'(s >>> bv);
    return av >> bv;
  endfunction

  // Clock edges from the accept edge up to the cycle in which done is high.
  function automatic int exp_edges(input logic [SHAMT_W-1:0] bv);
`ifdef SHR_FAST_EN
    return int'(bv) / 4 + int'(bv) % 4 + 1;
`else
    return int'(bv) + 1;
`endif
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one operation at the next falling edge and returns at the falling
  // edge where done is seen, so a following call issues at minimum interval.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [SHAMT_W-1:0] bv,
                        input logic ar);
    int edges;
    @(negedge clk);
    check("ready_before_start", {31'd0, ready}, 32'd1);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    a = av; b = bv; arith = ar; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs after accept; the DUT must use its latched copies.
    a = $urandom; b = SHAMT_W'($urandom); arith = 1'($urandom);
    edges = 1;
    while (!done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    check("latency", edges, exp_edges(bv));
    check("result", res, exp_shr(av, bv, ar));
    check("busy_at_done", {31'd0, busy}, 32'd1);
    check("ready_at_done", {31'd0, ready}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int edges;
    int dones;
    logic [WIDTH-1:0] held;

    rst_n = 1'b0; start = 1'b0; arith = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_out", res, 32'h0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // Logical full shift
    run_op(32'h8000_0000, 5'd31, 1'b0);
    check("full_shift_value", res, 32'h0000_0001);

    // Arithmetic shifts
    run_op(32'h8000_0000, 5'd4, 1'b1);
    check("sra_neg", res, 32'hF800_0000);
    run_op(32'h7FFF_FFF0, 5'd4, 1'b1);
    check("sra_pos", res, 32'h07FF_FFFF);

    // Zero shift, back-to-back at minimum issue interval
    run_op(32'h1234_5678, 5'd0, 1'b0);
    check("zero_shift", res, 32'h1234_5678);
    run_op(32'hDEAD_BEEF, 5'd0, 1'b1);
    run_op(32'hCAFE_F00D, 5'd1, 1'b1);

    // Fast-path directed case (also a plain case in the default build)
    run_op(32'hFFFF_FFFF, 5'd31, 1'b0);
    check("all_ones_31", res, 32'h0000_0001);

    // start while busy must be ignored
    @(negedge clk);
    a = 32'hFFFF_0000; b = 5'd8; arith = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    while (!done && edges < 100) begin
      if (edges == 2) begin
        start = 1'b1; a = 32'h1; b = 5'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check("busy_ign_latency", edges, exp_edges(5'd8));
    check("busy_ign_value", res, 32'h00FF_FF00);
    held = res;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("busy_ign_no_second_op", dones, 0);
    check("busy_ign_ready", {31'd0, ready}, 32'd1);
    check("busy_ign_out_held", res, held);

    // Reset in the middle of an operation
    @(negedge clk);
    a = 32'hA5A5_A5A5; b = 5'd20; arith = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_no_done", dones + int'(done), 0);
    check("midrst_out", res, 32'h0);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    run_op(32'h0000_0100, 5'd8, 1'b0);
    check("after_rst_value", res, 32'h0000_0001);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      run_op(WIDTH'($urandom), SHAMT_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check("final_ready", {31'd0, ready}, 32'd1);
    check("final_done", {31'd0, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Multi-cycle right shifter for the RV32 execute stage. Implements SRL/SRLI and SRA/SRAI, complementing the combinational left shifter.
- Iterates one bit position per clock under a start/ready/done handshake. This trades latency for area on the ALU shift path.
- The result is registered and held stable until the next completed operation.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width. Must satisfy 2**SHAMT_W == WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low. Sampled only on the rising edge of clk.
- start  in  1  request. Accepted only while ready=1.
- arith  in  1  1 = arithmetic shift (sign fill), 0 = logical shift (zero fill). Latched at accept.
- A  in  WIDTH  operand. Latched at accept.
- B  in  SHAMT_W  shift amount. Latched at accept.
- ready  out  1  high in IDLE.
- busy  out  1  high in SHIFT or DONE.
- done  out  1  one-cycle pulse: out holds the new result.
- out  out  WIDTH  registered result. Holds its value between operations.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, acc=0, cnt=0, sign=0, done=0, out=0, ready=1, busy=0.
  - Any in-flight operation is abandoned. No done pulse is produced for it.
- States:
  - IDLE: ready=1.
  - SHIFT: busy=1.
  - DONE: busy=1, done=1.
- IDLE with start=1 (accept edge):
  - acc<=A, cnt<=B, sign<=arith & A[WIDTH-1].
  - Next state is DONE if B==0, else SHIFT.
- SHIFT, each edge:
  - acc<={sign, acc[WIDTH-1:1]}, cnt<=cnt-1.
  - When cnt==1, next state is DONE.
- DONE, entry edge: out<=final acc.
  - In the final SHIFT cycle, out loads the shifted value directly so that out is correct while done=1.
  - DONE lasts exactly 1 cycle, then returns to IDLE.
- Latency:
  - done is high in the cycle B+1 cycles after the accept edge. For B=0 this is the cycle immediately after accept.
  - Issue interval is B+2 cycles (accept, B shift cycles, DONE).
- start is ignored while ready=0 (SHIFT or DONE). It is not queued. A, B and arith may change freely after accept.
- Width rules:
  - cnt is SHAMT_W bits and never underflows. B=31 yields 31 shift cycles.
  - Arithmetic fill replicates the latched A[WIDTH-1]. Logical fill is 0.
- Reset asserted during SHIFT or DONE:
  - Next cycle is IDLE with ready=1, out=0 and no done pulse.
  - start in the cycle after reset release is accepted normally.
- done and ready are never high in the same cycle.

Optional Feature:
- Macro: SHR_FAST_EN.
- Defined:
  - In SHIFT, if cnt>=4, shift by 4 (fill 4 sign/zero bits) and decrement cnt by 4. Otherwise shift by 1 as normal.
  - SHIFT cycles = floor(B/4) + (B mod 4).
  - done follows the last SHIFT cycle by 1 cycle.
  - Results are identical to the non-fast build.
- Undefined: 1 bit per cycle exactly as specified above. No 4-bit datapath is instantiated.

Test Plan:
- Logical full shift: reset, then start A=0x80000000 B=31 arith=0 → done exactly 32 cycles after accept, out=0x00000001, ready=1 on the following cycle.
- Arithmetic shift: A=0x80000000 B=4 arith=1 → out=0xF8000000 after 5 cycles. Repeat with A=0x7FFFFFF0 B=4 arith=1 → out=0x07FFFFFF.
- Zero shift: A=0x12345678 B=0 → done in the cycle after accept, out=0x12345678. Back-to-back ops at the minimum issue interval of 2 cycles both complete correctly.
- Busy ignore: accept A=0xFFFF0000 B=8 arith=0, then pulse start with A=0x1 B=1 during SHIFT → single done, out=0x00FFFF00, no second operation.
- Reset mid-op: accept B=20, assert rst_n=0 at cycle 5 for 1 cycle → no done, out=0, ready=1. New op A=0x100 B=8 → out=0x00000001.
- SHR_FAST_EN build: A=0xFFFFFFFF B=31 arith=0 → 10 SHIFT cycles, done 11 cycles after accept, out=0x00000001. Randomized A/B/arith results match the non-fast build.
